// File: rtl/approx_error_monitor.sv
// ---------------------------------------------------------------------------
// approx_error_monitor
//
// Error-characterisation stage for the approximate prefix adders. Each
// accepted sample carries the adder operands plus the approximate result.
// The exact sum is recomputed and statistics are accumulated over a window
// of 2^WINDOW_LOG2 samples: mismatch count, sum of error distances and the
// maximum error distance. The done flag marks results as valid.
//
// Optional feature: define APPROX_MON_BIAS_EN to add the signed bias_sum
// accumulator and port. The default build omits them.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   start       pulse, clears statistics and opens a window (IDLE/DONE only)
//   in_valid    sample present on the input bus
//   in_ready    monitor accepts a sample this cycle (registered)
//   op_a, op_b  adder operands (WIDTH bits)
//   cin         adder carry-in
//   approx_res  approximate result {carry_out, sum} (WIDTH+1 bits)
//   busy        window in progress (RUN or DRAIN)
//   done        results valid, held until next start or reset
//   err_count   samples whose approx_res differed from the exact sum
//   ed_sum      sum of |exact - approx_res|
//   ed_max      maximum |exact - approx_res|
//   bias_sum    signed sum of (approx_res - exact), APPROX_MON_BIAS_EN only
// ---------------------------------------------------------------------------
module approx_error_monitor #(
    parameter int WIDTH       = 16,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               op_a,
    input  logic [WIDTH-1:0]               op_b,
    input  logic                           cin,
    input  logic [WIDTH:0]                 approx_res,
    output logic                           busy,
    output logic                           done,
    output logic [WINDOW_LOG2:0]           err_count,
    output logic [WIDTH+WINDOW_LOG2:0]     ed_sum,
    output logic [WIDTH:0]                 ed_max
`ifdef APPROX_MON_BIAS_EN
    ,
    output logic [WIDTH+WINDOW_LOG2+1:0]   bias_sum
`endif
);

    localparam logic [WINDOW_LOG2:0] SAMPLES = (WINDOW_LOG2+1)'(1) << WINDOW_LOG2;
    localparam logic [WINDOW_LOG2:0] LAST    = SAMPLES - (WINDOW_LOG2+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic                   drain_reg, drain_next;
    logic [WINDOW_LOG2:0]   cnt_reg, cnt_next;
    logic                   in_ready_reg, in_ready_next;

    logic                   accept;
    logic                   start_clear;

    // S1 pipeline registers
    logic                   s1_valid_reg;
    logic [WIDTH:0]         s1_exact_reg;
    logic [WIDTH:0]         s1_approx_reg;

    // S2 combinational error terms
    logic [WIDTH:0]         diff_bits;
    logic                   mismatch;
    logic [WIDTH:0]         ed;

    // Statistics
    logic [WINDOW_LOG2:0]       err_count_reg;
    logic [WIDTH+WINDOW_LOG2:0] ed_sum_reg;
    logic [WIDTH:0]             ed_max_reg;

    assign accept      = in_valid && in_ready_reg;
    // start is only honoured between windows; inside a window it is ignored.
    assign start_clear = start && ((state_reg == IDLE) || (state_reg == DONE));

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        drain_next    = 1'b0;
        cnt_next      = cnt_reg;
        in_ready_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_next = cnt_reg + (WINDOW_LOG2+1)'(1);
                    if (cnt_reg == LAST) begin
                        state_next = DRAIN;
                    end
                end
                // Registered ready: stays low once the final sample is taken.
                in_ready_next = (cnt_next < SAMPLES);
            end
            DRAIN: begin
                // Two cycles lets the last sample pass S1 and S2.
                drain_next = 1'b1;
                if (drain_reg) begin
                    state_next = DONE;
                    drain_next = 1'b0;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            drain_reg    <= 1'b0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            drain_reg    <= drain_next;
            cnt_reg      <= cnt_next;
            in_ready_reg <= in_ready_next;
        end
    end

    // ---------------------------------------------------------------------
    // S1: capture exact sum and approximate result
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_exact_reg  <= '0;
            s1_approx_reg <= '0;
        end else begin
            s1_valid_reg <= accept && !start_clear;
            if (accept) begin
                s1_exact_reg  <= {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
                s1_approx_reg <= approx_res;
            end
        end
    end

    // ---------------------------------------------------------------------
    // S2: error distance and mismatch
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi <= WIDTH; gi++) begin : g_diff
            assign diff_bits[gi] = s1_exact_reg[gi] ^ s1_approx_reg[gi];
        end
    endgenerate

    assign mismatch = |diff_bits;
    assign ed = (s1_exact_reg >= s1_approx_reg) ? (s1_exact_reg - s1_approx_reg)
                                                : (s1_approx_reg - s1_exact_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_reg <= '0;
            ed_sum_reg    <= '0;
            ed_max_reg    <= '0;
        end else if (start_clear) begin
            err_count_reg <= '0;
            ed_sum_reg    <= '0;
            ed_max_reg    <= '0;
        end else if (s1_valid_reg) begin
            err_count_reg <= err_count_reg + {{WINDOW_LOG2{1'b0}}, mismatch};
            ed_sum_reg    <= ed_sum_reg + {{WINDOW_LOG2{1'b0}}, ed};
            if (ed > ed_max_reg) begin
                ed_max_reg <= ed;
            end
        end
    end

`ifdef APPROX_MON_BIAS_EN
    logic [WIDTH+1:0]             bias_diff;
    logic [WIDTH+WINDOW_LOG2+1:0] bias_sum_reg;

    // approx - exact as a signed WIDTH+2-bit value, sign-extended on add.
    assign bias_diff = {1'b0, s1_approx_reg} - {1'b0, s1_exact_reg};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bias_sum_reg <= '0;
        end else if (start_clear) begin
            bias_sum_reg <= '0;
        end else if (s1_valid_reg) begin
            bias_sum_reg <= bias_sum_reg + {{WINDOW_LOG2{bias_diff[WIDTH+1]}}, bias_diff};
        end
    end

    assign bias_sum = bias_sum_reg;
`endif

    assign in_ready  = in_ready_reg;
    assign busy      = (state_reg == RUN) || (state_reg == DRAIN);
    assign done      = (state_reg == DONE);
    assign err_count = err_count_reg;
    assign ed_sum    = ed_sum_reg;
    assign ed_max    = ed_max_reg;

endmodule
